// File: rtl/zip_memunit.sv
// zip_memunit -- single-outstanding-operation CPU memory unit.
//
// Takes one load/store at a time from the CPU memory stage and runs it as a
// pipelined Wishbone bus cycle, then reports completion back to the CPU.
//
// Optional build macro: ZIP_MEMUNIT_ALIGN_ERR_EN
//   defined   : misaligned word/half requests raise o_err with no bus cycle
//   undefined : misaligned low address bits are ignored
//
// Parameters:
//   OPT_LOCK         - hold o_wb_cyc across requests while i_lock is set
//   OPT_ZERO_ON_IDLE - drive o_wb_addr/o_wb_data/o_wb_sel to zero while !o_wb_stb
//
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_stb, i_lock, i_op      CPU request strobe, lock, operation code
//   i_addr, i_data, i_oreg   byte address, store data, load destination
//   o_busy, o_rdbusy         operation / load in progress
//   o_pipe_stalled           same as o_busy
//   o_done, o_valid, o_err   completion pulses
//   o_wreg, o_result         load write-back register and data
//   o_wb_*                   Wishbone master outputs
//   i_wb_*                   Wishbone slave responses
module zip_memunit #(
    parameter logic OPT_LOCK         = 1'b0,
    parameter logic OPT_ZERO_ON_IDLE = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stb,
    input  logic        i_lock,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  logic [4:0]  i_oreg,
    output logic        o_busy,
    output logic        o_rdbusy,
    output logic        o_pipe_stalled,
    output logic        o_done,
    output logic        o_valid,
    output logic        o_err,
    output logic [4:0]  o_wreg,
    output logic [31:0] o_result,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [29:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_stall,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_data
);

`ifdef ZIP_MEMUNIT_ALIGN_ERR_EN
    localparam logic ALIGN_CHECK = 1'b1;
`else
    localparam logic ALIGN_CHECK = 1'b0;
`endif

    // LOCKED keeps the bus cycle open with nothing outstanding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    // Size encoding is i_op[2:1]: 01 word, 10 half, 11 byte.
    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] s;
        case (size)
            2'b01:   s = 4'b1111;
            2'b10:   s = a[1] ? 4'b0011 : 4'b1100;
            2'b11:   s = 4'b1000 >> a;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            2'b01:   r = d;
            2'b10:   r = {2{d[15:0]}};
            2'b11:   r = {4{d[7:0]}};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Big-endian lanes: byte offset 0 lives in bits [31:24].
    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] a,
                                                 input logic [31:0] d);
        logic [31:0] r;
        logic [31:0] sh;
        sh = d >> {~a, 3'b000};
        case (size)
            2'b01:   r = d;
            2'b10:   r = a[1] ? {16'd0, d[15:0]} : {16'd0, d[31:16]};
            2'b11:   r = {24'd0, sh[7:0]};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        return ALIGN_CHECK && (((size == 2'b01) && (a != 2'b00)) || ((size == 2'b10) && a[0]));
    endfunction

    state_t      state_q, state_d;
    logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic        busy_q, busy_d, rdbusy_q, rdbusy_d;
    logic        done_q, done_d, valid_q, valid_d, err_q, err_d;
    logic        lock_q, lock_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] result_q, result_d;
    logic [29:0] addr_q, addr_d, addr_z;
    logic [31:0] data_q, data_d, data_z;
    logic [3:0]  sel_q, sel_d, sel_z;
    logic [1:0]  size_q, size_d, low_q, low_d;
    logic        accept_s, bad_req_s;

    // Next-state and next-output logic for the request/response sequencer.
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        busy_d    = busy_q;
        rdbusy_d  = rdbusy_q;
        done_d    = 1'b0;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        lock_d    = lock_q;
        wreg_d    = wreg_q;
        result_d  = result_q;
        addr_d    = addr_q;
        data_d    = data_q;
        sel_d     = sel_q;
        size_d    = size_q;
        low_d     = low_q;
        accept_s  = i_stb && !busy_q;
        bad_req_s = (i_op[2:1] == 2'b00) || misaligned(i_op[2:1], i_addr[1:0]);

        case (state_q)
            ST_IDLE, ST_LOCKED: begin
                // Responses are ignored here: nothing is outstanding.
                if (accept_s && bad_req_s) begin
                    // Rejected without touching the bus; any held lock is released.
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    lock_d  = 1'b0;
                end else if (accept_s) begin
                    state_d  = ST_REQ;
                    cyc_d    = 1'b1;
                    stb_d    = 1'b1;
                    busy_d   = 1'b1;
                    rdbusy_d = !i_op[0];
                    we_d     = i_op[0];
                    wreg_d   = i_oreg;
                    addr_d   = i_addr[31:2];
                    data_d   = store_data(i_op[2:1], i_data);
                    sel_d    = lane_sel(i_op[2:1], i_addr[1:0]);
                    size_d   = i_op[2:1];
                    low_d    = i_addr[1:0];
                    lock_d   = OPT_LOCK && i_lock;
                end else if ((state_q == ST_LOCKED) && !i_lock) begin
                    state_d = ST_IDLE;
                    cyc_d   = 1'b0;
                    lock_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_REQ, ST_WAIT: begin
                // A response may arrive while stb is still up; it completes the op.
                if (i_wb_err) begin
                    err_d    = 1'b1;
                    state_d  = ST_IDLE;
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    busy_d   = 1'b0;
                    rdbusy_d = 1'b0;
                    lock_d   = 1'b0;
                end else if (i_wb_ack) begin
                    done_d   = 1'b1;
                    valid_d  = !we_q;
                    stb_d    = 1'b0;
                    busy_d   = 1'b0;
                    rdbusy_d = 1'b0;
                    if (!we_q) begin
                        result_d = load_extract(size_q, low_q, i_wb_data);
                    end else begin
                        result_d = result_q;
                    end
                    if (lock_q && i_lock) begin
                        state_d = ST_LOCKED;
                        cyc_d   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cyc_d   = 1'b0;
                        lock_d  = 1'b0;
                    end
                end else if ((state_q == ST_REQ) && !i_wb_stall) begin
                    state_d = ST_WAIT;
                    stb_d   = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cyc_d    = 1'b0;
                stb_d    = 1'b0;
                busy_d   = 1'b0;
                rdbusy_d = 1'b0;
                lock_d   = 1'b0;
            end
        endcase
    end

    // Blank the address/data/lane outputs whenever no strobe will be presented.
    always_comb begin
        if (OPT_ZERO_ON_IDLE && !stb_d) begin
            addr_z = 30'd0;
            data_z = 32'd0;
            sel_z  = 4'd0;
        end else begin
            addr_z = addr_d;
            data_z = data_d;
            sel_z  = sel_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            rdbusy_q <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            lock_q   <= 1'b0;
            wreg_q   <= 5'd0;
            result_q <= 32'd0;
            addr_q   <= 30'd0;
            data_q   <= 32'd0;
            sel_q    <= 4'd0;
            size_q   <= 2'd0;
            low_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            rdbusy_q <= rdbusy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            lock_q   <= lock_d;
            wreg_q   <= wreg_d;
            result_q <= result_d;
            addr_q   <= addr_z;
            data_q   <= data_z;
            sel_q    <= sel_z;
            size_q   <= size_d;
            low_q    <= low_d;
        end
    end

    assign o_busy         = busy_q;
    assign o_rdbusy       = rdbusy_q;
    assign o_pipe_stalled = busy_q;
    assign o_done         = done_q;
    assign o_valid        = valid_q;
    assign o_err          = err_q;
    assign o_wreg         = wreg_q;
    assign o_result       = result_q;
    assign o_wb_cyc       = cyc_q;
    assign o_wb_stb       = stb_q;
    assign o_wb_we        = we_q;
    assign o_wb_addr      = addr_q;
    assign o_wb_data      = data_q;
    assign o_wb_sel       = sel_q;

endmodule

// File: doc/zip_memunit.md
Name: zip_memunit

Overview:
- Single-outstanding-operation CPU memory unit: the responder side of the CPU-to-memory interface.
- Accepts load/store requests from the CPU pipeline and issues them as Wishbone (pipelined) bus cycles.
- Returns busy, rdbusy, done, valid, err, the write-back register and the read result to the CPU.
- Sits between the CPU's memory stage and the bus interconnect.

Parameters:
- OPT_LOCK, 1'b0, when 1, honour i_lock by holding o_wb_cyc across consecutive requests.
- OPT_ZERO_ON_IDLE, 1'b0, when 1, drive o_wb_addr/o_wb_data/o_wb_sel to zero whenever o_wb_stb is low.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous active-high reset; aborts any bus cycle
- i_stb  in  1  CPU request strobe; accepted when !o_busy
- i_lock  in  1  CPU lock request (ignored unless OPT_LOCK)
- i_op  in  3  [2:1]: 01 word, 10 half, 11 byte, 00 illegal; [0]: 1 store, 0 load
- i_addr  in  32  byte address
- i_data  in  32  store data, right-justified
- i_oreg  in  5  destination register for loads, [4] = gie
- o_busy  out  1  operation in progress
- o_rdbusy  out  1  load in progress
- o_pipe_stalled  out  1  equals o_busy
- o_done  out  1  one-cycle pulse, operation complete (load or store)
- o_valid  out  1  one-cycle pulse, load data valid
- o_err  out  1  one-cycle pulse, bus/alignment error
- o_wreg  out  5  register for o_result
- o_result  out  32  zero-extended load data
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone control
- o_wb_addr  out  30  word address
- o_wb_data  out  32  write data
- o_wb_sel  out  4  byte lanes, big-endian
- i_wb_stall, i_wb_ack, i_wb_err  in  1 each  Wishbone responses
- i_wb_data  in  32  read data

Behaviour:
- Clock and reset: one clock i_clk; reset i_reset is synchronous, active-high.
- Reset values: all outputs 0, including cyc/stb/busy/rdbusy/done/valid/err/wreg/result/sel.
- States: IDLE, REQ (cyc=stb=1), WAIT (cyc=1, stb=0), and with OPT_LOCK, LOCKED (cyc=1, stb=0, no op outstanding).
- Accept: i_stb && !o_busy. On the next cycle: cyc=stb=1, o_busy=1, o_rdbusy=!i_op[0], o_wreg=i_oreg, and addr/data/sel/we registered.
- REQ to WAIT on !i_wb_stall.
- Completion: i_wb_ack or i_wb_err while cyc=1, including in the same cycle stb is accepted. The next cycle:
  - o_done=1 on ack;
  - o_valid=1 on ack of a load;
  - o_err=1 on err;
  - o_busy=o_rdbusy=0;
  - stb=0;
  - cyc=0, unless OPT_LOCK and the locked condition holds.
- Minimum latency: accept at cycle 0, stb at 1, ack at 1, done/valid at 2.
- Lane selection, big-endian:
  - word: sel 1111.
  - half: addr[1]=0 gives 1100, addr[1]=1 gives 0011; data {d[15:0],d[15:0]}.
  - byte: addr[1:0] 00/01/10/11 gives 1000/0100/0010/0001; data replicated x4.
- Load result: selected lanes right-justified, upper bits zero.
- o_wb_addr = i_addr[31:2].
- i_op[2:1]==00: treated as an alignment error (o_err pulse next cycle, no bus cycle).
- Ack/err with cyc=0: ignored.
- i_stb while o_busy: ignored (CPU contract forbids it).
- Reset mid-operation: cyc/stb low on the next cycle; no done/valid/err generated from the aborted cycle.
- Error: cyc drops on the next cycle regardless of lock; o_result is unchanged.
- OPT_LOCK:
  - accepting with i_lock=1 keeps cyc high after completion (LOCKED);
  - a new request from LOCKED goes directly to REQ;
  - i_lock=0 while LOCKED and idle drops cyc on the next cycle.

Optional Feature:
- Macro: ZIP_MEMUNIT_ALIGN_ERR_EN.
- Defined: word with addr[1:0]!=0, or half with addr[0]=1, issues no bus cycle; o_err pulses the cycle after accept; o_busy stays low.
- Undefined: misaligned low bits are ignored (word uses addr[31:2]; half uses addr[1]).

Test Plan:
- Word store, addr 0x100, data 0xDEADBEEF, ack the cycle after stb -> wb_addr 0x40, sel 1111, we=1; o_done pulses at cycle 2; o_valid stays 0.
- Byte load, addr 0x203, oreg 5'h03, i_wb_data 0x11223344, stall 2 cycles -> sel 0001; stb held 3 cycles; o_valid with o_result 0x00000044, o_wreg 3.
- Half load, addr 0x10 -> sel 1100; ack data 0xABCD1234 -> o_result 0x0000ABCD; o_rdbusy high from accept until o_valid.
- Load answered with i_wb_err -> o_err pulse, no o_valid, cyc low the next cycle; with OPT_LOCK and i_lock=1, cyc still drops.
- i_reset asserted while in WAIT, then a late i_wb_ack -> cyc low after reset; no done/valid/err; o_busy=0.
- With ZIP_MEMUNIT_ALIGN_ERR_EN, word load addr 0x102 -> no cyc, o_err pulse at cycle 1; without the macro -> normal cycle, wb_addr 0x40.
